exec_monitor: RTL and testbench

Synthesizable run monitor for the RV32I core. It watches the fetch stream (`pc`, `instr`) from the moment a start pulse arrives and counts cycles and PC advances. It stops the run on the first of four terminal conditions: invalid fetch, halt instruction, stalled PC, or cycle budget exhausted. It generalises the fixed 256-iteration, stop-on-undefined-instruction bench loop into a parametrised, reusable block that sits beside `Top` in the bench or on the board, with its status brought out to LEDs.

---
 rtl/exec_monitor.sv | 153 +++++++++++++++
 tb/tb_exec_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/exec_monitor.sv
// Run monitor for the RV32I fetch stream: counts RUN cycles and PC advances and
// stops on an invalid fetch, the halt word, a stalled PC or an exhausted cycle budget.
module exec_monitor #(
  parameter int                 PC_W        = 16,
  parameter int                 INSTR_W     = 32,
  parameter int                 CNT_W       = 16,
  parameter int                 MAX_CYCLES  = 256,
  parameter int                 STALL_LIMIT = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = 32'h0000_0073
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               running,
  output logic               done,
  output logic [2:0]         cause,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   retired,
  output logic [PC_W-1:0]    last_pc
);

  localparam int SW = $clog2(STALL_LIMIT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [2:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic              first_q, first_d;
  logic              same_s;
  logic [2:0]        term_s;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cause_q   <= 3'd0;
      cycles_q  <= '0;
      retired_q <= '0;
      last_pc_q <= '0;
      prev_pc_q <= '0;
      stall_q   <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
      prev_pc_q <= prev_pc_d;
      stall_q   <= stall_d;
      first_q   <= first_d;
    end
  end

  // Next-state, counter and termination logic
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    done_d    = done_q;
    cause_d   = cause_q;
    cycles_d  = cycles_q;
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    prev_pc_d = prev_pc_q;
    stall_d   = stall_q;
    first_d   = first_q;
    same_s    = 1'b0;
    term_s    = 3'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          running_d = 1'b1;
          done_d    = 1'b0;
          cause_d   = 3'd0;
          cycles_d  = '0;
          retired_d = '0;
          stall_d   = '0;
          first_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        cycles_d = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + CNT_W'(1);
        same_s   = !first_q && (pc == prev_pc_q);
        if (same_s) begin
          stall_d = stall_q + SW'(1);
        end else begin
          retired_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);
          stall_d   = '0;
        end
        prev_pc_d = pc;
        first_d   = 1'b0;

        // Priority: invalid > halt > stall > timeout; comparisons use pre-update values
        if (!instr_valid) begin
          term_s = 3'd1;
        end else if (instr == HALT_INSTR) begin
          term_s = 3'd2;
        end else if (same_s && (stall_q == SW'(STALL_LIMIT - 1))) begin
          term_s = 3'd3;
        end else if (cycles_q == CNT_W'(MAX_CYCLES - 1)) begin
          term_s = 3'd4;
        end else begin
          term_s = 3'd0;
        end

        if (term_s != 3'd0) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          cause_d   = term_s;
          last_pc_d = pc;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d   = S_IDLE;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  assign running = running_q;
  assign done    = done_q;
  assign cause   = cause_q;
  assign cycles  = cycles_q;
  assign retired = retired_q;
  assign last_pc = last_pc_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Directed, table-driven bench for exec_monitor with hand-computed expectations.
module tb_exec_monitor;

  localparam logic [31:0] HALT = 32'h0000_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        running;
  logic        done;
  logic [2:0]  cause;
  logic [15:0] cycles;
  logic [15:0] retired;
  logic [15:0] last_pc;

  int checks   = 0;
  int failures = 0;

  exec_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .running     (running),
    .done        (done),
    .cause       (cause),
    .cycles      (cycles),
    .retired     (retired),
    .last_pc     (last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        e_run;
    logic        e_done;
    logic [2:0]  e_cause;
    logic [15:0] e_cyc;
    logic [15:0] e_ret;
    logic [15:0] e_last;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_run, input logic e_done,
                         input logic [2:0] e_cause, input logic [15:0] e_cyc,
                         input logic [15:0] e_ret, input logic [15:0] e_last);
    chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
    chk({tag, ".done"},    {31'd0, done},    {31'd0, e_done});
    chk({tag, ".cause"},   {29'd0, cause},   {29'd0, e_cause});
    chk({tag, ".cycles"},  {16'd0, cycles},  {16'd0, e_cyc});
    chk({tag, ".retired"}, {16'd0, retired}, {16'd0, e_ret});
    chk({tag, ".last_pc"}, {16'd0, last_pc}, {16'd0, e_last});
  endtask

  // Drive on the falling edge, let the rising edge sample, observe 1 time unit later.
  task automatic step(input logic s, input logic [15:0] p, input logic [31:0] ins, input logic v);
    @(negedge clk);
    start       = s;
    pc          = p;
    instr       = ins;
    instr_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          start pc      instr valid run done cause cyc  ret  last
    tbl[0]  = '{1'b1, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'h0};
    tbl[1]  = '{1'b0, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'd1, 16'h0};
    tbl[2]  = '{1'b0, 16'h4,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd2, 16'd2, 16'h0};
    tbl[3]  = '{1'b0, 16'h8,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd3, 16'd3, 16'h0};
    tbl[4]  = '{1'b0, 16'hC,  HALT, 1'b1, 1'b0, 1'b1, 3'd2, 16'd4, 16'd4, 16'hC};
    tbl[5]  = '{1'b0, 16'h64, NOP,  1'b1, 1'b0, 1'b1, 3'd2, 16'd4, 16'd4, 16'hC};
    // restart from DONE into a stall run; start mid-run must be ignored
    tbl[6]  = '{1'b1, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'hC};
    tbl[7]  = '{1'b0, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'd1, 16'hC};
    tbl[8]  = '{1'b1, 16'h4,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd2, 16'd2, 16'hC};
    tbl[9]  = '{1'b0, 16'h8,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd3, 16'd3, 16'hC};
    tbl[10] = '{1'b0, 16'h8,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd4, 16'd3, 16'hC};
    tbl[11] = '{1'b0, 16'h8,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd5, 16'd3, 16'hC};
    tbl[12] = '{1'b0, 16'h8,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd6, 16'd3, 16'hC};
    tbl[13] = '{1'b0, 16'h8,  NOP,  1'b1, 1'b0, 1'b1, 3'd3, 16'd7, 16'd3, 16'h8};
    // invalid and halt on the same edge: invalid wins
    tbl[14] = '{1'b1, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'h8};
    tbl[15] = '{1'b0, 16'h20, NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'd1, 16'h8};
    tbl[16] = '{1'b0, 16'h24, HALT, 1'b0, 1'b0, 1'b1, 3'd1, 16'd2, 16'd2, 16'h24};
    // halt at a repeated PC is not counted as retired
    tbl[17] = '{1'b1, 16'h0,  NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'h24};
    tbl[18] = '{1'b0, 16'h40, NOP,  1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'd1, 16'h24};
    tbl[19] = '{1'b0, 16'h40, HALT, 1'b1, 1'b0, 1'b1, 3'd2, 16'd2, 16'd1, 16'h40};

    rst_n       = 1'b0;
    start       = 1'b0;
    pc          = 16'h0;
    instr       = NOP;
    instr_valid = 1'b1;
    #12;
    chk_all("reset", 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].start, tbl[i].pc, tbl[i].instr, tbl[i].valid);
      chk_all($sformatf("vec%0d", i), tbl[i].e_run, tbl[i].e_done, tbl[i].e_cause,
              tbl[i].e_cyc, tbl[i].e_ret, tbl[i].e_last);
    end

    // Timeout: pc steps by 4 each RUN edge, budget is 256 edges
    step(1'b1, 16'h0, NOP, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      step(1'b0, 16'((k - 1) * 4), NOP, 1'b1);
      if (k == 255) chk("timeout.still_running", {31'd0, running}, 32'd1);
    end
    chk_all("timeout", 1'b0, 1'b1, 3'd4, 16'd256, 16'd256, 16'h3FC);

    // Asynchronous reset mid-run at cycles=50
    step(1'b1, 16'h0, NOP, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 16'((k - 1) * 4), NOP, 1'b1);
    end
    chk("midrun.cycles", {16'd0, cycles}, 32'd50);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h100, NOP, 1'b1);
    chk_all("post_reset_start", 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 16'h0);
    step(1'b0, 16'h100, NOP, 1'b1);
    step(1'b0, 16'h104, HALT, 1'b1);
    chk_all("post_reset_halt", 1'b0, 1'b1, 3'd2, 16'd2, 16'd2, 16'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
